// File: rtl/timing_pkg.sv
// timing_pkg: shared types and constants for the control-unit timing sequencer.
package timing_pkg;

  localparam int SC_WIDTH    = 4;
  localparam int PHASE_COUNT = 2 ** SC_WIDTH;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/sc_counter.sv
// sc_counter: sequence counter with clear/increment, terminal-count flag and
// one-hot phase decode. The phase bus is forced to zero when en is low.
module sc_counter #(
  parameter int SC_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        inc,
  input  logic                        en,
  output logic [SC_WIDTH-1:0]         sc,
  output logic                        tc,
  output logic [0:(2**SC_WIDTH)-1]    T
);

  // Counter register; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset)   sc <= '0;
    else if (clr) sc <= '0;
    else if (inc) sc <= sc + 1'b1;
  end

  assign tc = (sc == '1);

  // One-hot decode: T[i] is phase i, all-zero while disabled.
  always_comb begin
    T = '0;
    if (en) T[sc] = 1'b1;
  end

endmodule

// File: rtl/timing_controller.sv
// timing_controller: run/halt/single-step sequencing of the T0..T15 phase bus.
// Single-step support is compiled in only when TIMING_CTRL_STEP_EN is defined;
// otherwise step_mode is ignored and PAUSE cannot be reached.
//
//   state | meaning
//   HALT  | idle, T all-zero, waits for start
//   RUN   | one phase per cycle, T[sc] high
//   PAUSE | single-step stop after an instruction, waits for start or halt_req
module timing_controller #(
  parameter int SC_WIDTH  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     halt_req,
  input  logic                     sc_clr,
  input  logic                     step_mode,
  output logic [0:(2**SC_WIDTH)-1] T,
  output logic [SC_WIDTH-1:0]      sc,
  output logic                     running,
  output logic                     instr_done,
  output logic                     overrun,
  output logic [CNT_WIDTH-1:0]     instr_count
);

  import timing_pkg::*;

`ifdef TIMING_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  state_t state, state_next;
  logic   halt_pending;
  logic   tc;
  logic   end_instr;
  logic   cnt_clr;
  logic   cnt_inc;

  // The last phase is either decoder-flagged or the wrap out of T15.
  assign end_instr = (state == RUN) && (sc_clr || tc);

  sc_counter #(
    .SC_WIDTH (SC_WIDTH)
  ) u_sc_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .en    (running),
    .sc    (sc),
    .tc    (tc),
    .T     (T)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= HALT;
    else        state <= state_next;
  end

  // Next-state logic; a pending or current halt request beats single-step.
  always_comb begin
    state_next = state;
    case (state)
      HALT: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (end_instr) begin
          if (halt_req || halt_pending)  state_next = HALT;
          else if (STEP_EN && step_mode) state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (halt_req)   state_next = HALT;
        else if (start) state_next = RUN;
      end
      default: state_next = HALT;
    endcase
  end

  // Outputs and counter control; sc is held at zero outside RUN so every
  // entry into RUN begins at T0.
  always_comb begin
    running = (state == RUN);
    cnt_inc = (state == RUN);
    cnt_clr = (state != RUN) || end_instr;
  end

  // A halt request seen mid-instruction is remembered until HALT is entered.
  always_ff @(posedge clk) begin
    if (!reset)                                        halt_pending <= 1'b0;
    else if (state_next == HALT)                       halt_pending <= 1'b0;
    else if ((state == RUN) && halt_req && !end_instr) halt_pending <= 1'b1;
  end

  // Completion bookkeeping: done pulse, instruction count and sticky overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_done  <= 1'b0;
      instr_count <= '0;
      overrun     <= 1'b0;
    end else begin
      instr_done <= end_instr;
      if (end_instr)                      instr_count <= instr_count + 1'b1;
      if ((state == RUN) && tc && !sc_clr) overrun     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timing_controller.sv
// Testbench for timing_controller: directed scenarios plus randomized
// stimulus, all checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_timing_controller;

`ifdef TIMING_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  localparam int S_HALT  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        sc_clr = 1'b0;
  logic        step_mode = 1'b0;
  logic [0:15] T;
  logic [3:0]  sc;
  logic        running;
  logic        instr_done;
  logic        overrun;
  logic [15:0] instr_count;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int          m_state = S_HALT;
  logic [3:0]  m_sc = 4'd0;
  bit          m_pend = 1'b0;
  bit          m_over = 1'b0;
  bit          m_done = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  logic [38:0] act;
  assign act = {T, sc, running, instr_done, overrun, instr_count};

  timing_controller #(.SC_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt_req    (halt_req),
    .sc_clr      (sc_clr),
    .step_mode   (step_mode),
    .T           (T),
    .sc          (sc),
    .running     (running),
    .instr_done  (instr_done),
    .overrun     (overrun),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // One clock of the specified behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit ends;
    if (!reset) begin
      m_state = S_HALT; m_sc = 0; m_pend = 0; m_over = 0; m_done = 0; m_cnt = 0;
      return;
    end
    m_done = 0;
    case (m_state)
      S_HALT: if (start) begin m_state = S_RUN; m_sc = 0; end
      S_RUN: begin
        ends = sc_clr || (m_sc == 4'd15);
        if (ends) begin
          m_cnt  = m_cnt + 16'd1;
          m_done = 1;
          if (m_sc == 4'd15 && !sc_clr) m_over = 1;
          m_sc = 0;
          if (halt_req || m_pend) begin m_state = S_HALT; m_pend = 0; end
          else if (STEP_EN && step_mode) m_state = S_PAUSE;
        end else begin
          m_sc = m_sc + 4'd1;
          if (halt_req) m_pend = 1;
        end
      end
      default: begin
        if (halt_req) begin m_state = S_HALT; m_pend = 0; end
        else if (start) m_state = S_RUN;
      end
    endcase
  endtask

  function automatic logic [38:0] exp_vec();
    logic [15:0] t;
    t = (m_state == S_RUN) ? (16'h8000 >> m_sc) : 16'h0000;
    return {t, m_sc, (m_state == S_RUN), m_done, m_over, m_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 0; start = 0; halt_req = 0; sc_clr = 0; step_mode = 0;
    tick(); tick();
    reset = 1;
  endtask

  task automatic test_reset();
    reset = 0; start = 1; sc_clr = 1; halt_req = 1;
    tick(); tick();
    vectors++;
    if (act !== 39'h0) begin
      miscompares++;
      $display("FAIL reset_values: got %h expected %h", act, 39'h0);
    end
    reset = 1; start = 0; sc_clr = 0; halt_req = 0;
    tick();
    vectors++;
    if (act !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_overrun();
    do_reset();
    start = 1; tick(); start = 0;
    vectors++;
    if (T !== 16'h8000 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL start_t0: got T=%h running=%b expected T=8000 running=1", T, running);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL overrun_seq[%0d]: got %h expected %h", i, act, exp_vec());
      end
    end
    vectors++;
    if (overrun !== 1'b1 || instr_count !== 16'd1 || T !== 16'h8000 || instr_done !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_end: got ov=%b cnt=%0d T=%h done=%b expected ov=1 cnt=1 T=8000 done=1",
               overrun, instr_count, T, instr_done);
    end
  endtask

  task automatic test_sc_clr();
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 12; i++) begin
      sc_clr = (m_state == S_RUN) && (m_sc == 4'd3);
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL sc_clr_t3[%0d]: got %h expected %h", i, act, exp_vec());
      end
    end
    sc_clr = 0;
    vectors++;
    if (instr_count !== 16'd3 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL sc_clr_count: got cnt=%0d ov=%b expected cnt=3 ov=0", instr_count, overrun);
    end
  endtask

  task automatic test_halt();
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 10; i++) begin
      halt_req = (m_state == S_RUN) && (m_sc == 4'd1);
      sc_clr   = (m_state == S_RUN) && (m_sc == 4'd5);
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL halt_seq[%0d]: got %h expected %h", i, act, exp_vec());
      end
    end
    halt_req = 0; sc_clr = 0;
    vectors++;
    if (running !== 1'b0 || T !== 16'h0 || instr_count !== 16'd1) begin
      miscompares++;
      $display("FAIL halt_idle: got run=%b T=%h cnt=%0d expected run=0 T=0000 cnt=1",
               running, T, instr_count);
    end
    start = 1; tick(); start = 0;
    vectors++;
    if (T !== 16'h8000 || act !== exp_vec()) begin
      miscompares++;
      $display("FAIL halt_resume: got %h expected %h", act, exp_vec());
    end
  endtask

  task automatic test_step();
    do_reset();
    step_mode = 1;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 12; i++) begin
      sc_clr = (m_state == S_RUN) && (m_sc == 4'd2);
      start  = (i == 7);
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL step_seq[%0d]: got %h expected %h", i, act, exp_vec());
      end
    end
    sc_clr = 0; start = 0;
    halt_req = 1; tick(); halt_req = 0;
    vectors++;
    if (act !== exp_vec()) begin
      miscompares++;
      $display("FAIL step_halt: got %h expected %h", act, exp_vec());
    end
    step_mode = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 7; i++) tick();
    vectors++;
    if (sc !== 4'd7) begin
      miscompares++;
      $display("FAIL reach_t7: got sc=%0d expected 7", sc);
    end
    reset = 0; tick(); reset = 1;
    vectors++;
    if (act !== 39'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h expected %h", act, 39'h0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start = 1; sc_clr = 1;
    for (int i = 0; i < 65540; i++) begin
      tick();
      if ((i % 2048) == 0 || m_cnt >= 16'hFFFE || m_cnt <= 16'd2) begin
        vectors++;
        if (act !== exp_vec()) begin
          miscompares++;
          $display("FAIL back_to_back[%0d]: got %h expected %h", i, act, exp_vec());
        end
      end
    end
    start = 0; sc_clr = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) >= 2);
      start     = ($urandom_range(0, 99) < 20);
      halt_req  = ($urandom_range(0, 99) < 5);
      sc_clr    = ($urandom_range(0, 99) < 15);
      step_mode = ($urandom_range(0, 99) < 40);
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h", i, act, exp_vec());
      end
    end
    reset = 1; start = 0; halt_req = 0; sc_clr = 0; step_mode = 0;
  endtask

  initial begin
    test_reset();
    test_overrun();
    test_sc_clr();
    test_halt();
    test_step();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
